// File: rtl/clk_ratio_monitor.sv
// Frequency-ratio checker: counts synchronized ref_clk rising edges over a fixed
// window of clk_div3 cycles and flags whether the count is within TOL of EXP_EDGES.
`timescale 1ns / 1ps

module clk_ratio_monitor #(
  parameter int unsigned WINDOW    = 15,
  parameter int unsigned EXP_EDGES = 9,
  parameter int unsigned TOL       = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk_div3,
  input  logic             rst_n,
  input  logic             ref_clk,
  input  logic             start,
  input  logic             cont_en,
  input  logic             clr_err,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] edge_count,
  output logic             err_sticky
);

  localparam int unsigned WinW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WinW-1:0] WinLast = WinW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StMeas, StDone} state_e;

  state_e            state_q, state_d;
  logic              s1_q, s2_q, s3_q;
  logic              rise;
  logic [WinW-1:0]   win_q, win_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  final_cnt;
  logic [CNT_W-1:0]  edge_count_q, edge_count_d;
  logic              pass_q, pass_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              result;
  logic              result_pass;
  logic [31:0]       final_ext;
  logic [31:0]       abs_diff;

  // Only the synchronized edge (s2 vs s3) reaches the counting logic.
  always_ff @(posedge clk_div3 or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= ref_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // Saturating count including the rise present on the current edge.
  always_comb begin
    final_cnt = cnt_q;
    if (rise && (cnt_q != CntMax)) begin
      final_cnt = cnt_q + CNT_W'(1);
    end
  end

  // Unsigned magnitude in 32 bits so neither direction can underflow.
  always_comb begin
    final_ext = 32'(final_cnt);
    if (final_ext >= EXP_EDGES) begin
      abs_diff = final_ext - EXP_EDGES;
    end else begin
      abs_diff = EXP_EDGES - final_ext;
    end
    result_pass = (abs_diff <= TOL);
  end

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    edge_count_d = edge_count_q;
    pass_d       = pass_q;
    err_d        = err_q;
    result       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StMeas;
          win_d   = '0;
          cnt_d   = '0;
        end
      end
      StMeas: begin
        cnt_d = final_cnt;
        win_d = win_q + WinW'(1);
        if (win_q == WinLast) begin
          state_d = StDone;
          result  = 1'b1;
        end
      end
      StDone: begin
        if (cont_en || start) begin
          state_d = StMeas;
          win_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (result) begin
      edge_count_d = final_cnt;
      pass_d       = result_pass;
    end

    // A failing result on the same edge as a clear keeps the flag set.
    if (clr_err) begin
      err_d = 1'b0;
    end
    if (result && !result_pass) begin
      err_d = 1'b1;
    end

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk_div3 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      win_q        <= '0;
      cnt_q        <= '0;
      edge_count_q <= '0;
      pass_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      edge_count_q <= edge_count_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign edge_count = edge_count_q;
  assign err_sticky = err_q;

endmodule
